restoring_divider_ctrl: RTL

- Sequential restoring divider built on the team's two's-complement subtract datapath.
- Accepts a dividend/divisor pair and runs one subtract-and-compare per clock.
- Keeps the partial remainder when the subtract's carry-out is 1 (no borrow); otherwise restores the previous remainder.
- Sits directly downstream of the subtractor: it consumes the subtractor's result and carry each cycle, and drives its operands.

---
 rtl/restoring_divider_ctrl_pkg.sv | 19 +
 rtl/restoring_divider_ctrl_sub_stage.sv | 17 +
 rtl/restoring_divider_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/restoring_divider_ctrl_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and counter sizing.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        FIXUP = 2'd3
    } state_t;

    localparam int DIV_WIDTH_DEFAULT = 4;
    localparam int CNT_W             = $clog2(DIV_WIDTH_DEFAULT);

    // Iteration counter width for a given operand width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/restoring_divider_ctrl_sub_stage.sv
// Combinational WIDTH+1-bit two's-complement subtract: diff = a - b, carry=1 means no borrow.
module div_sub_stage #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] diff,
    output logic           carry
);

    logic [WIDTH+1:0] sum;

    assign sum   = {1'b0, a} + {1'b0, ~b} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign diff  = sum[WIDTH:0];
    assign carry = sum[WIDTH+1];

endmodule

// File: rtl/restoring_divider_ctrl.sv
// Sequential restoring divider, one subtract-and-compare per clock.
// Define DIV_SIGNED_EN for two's-complement operands (adds a FIXUP cycle).
module restoring_divider_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH:0]   r_reg;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   sub_diff;
    logic             sub_carry;
    logic [WIDTH:0]   r_iter;
    logic [WIDTH-1:0] q_iter;
    logic             accept;
    logic             unused_r_msb;

`ifdef DIV_SIGNED_EN
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;

    // The most-negative value maps onto itself, which reads correctly as its unsigned magnitude.
    assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
`endif

    assign accept       = in_valid & in_ready;
    assign r_shift      = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    // The partial remainder never reaches 2^WIDTH after a step, so its top bit is never consumed.
    assign unused_r_msb = r_reg[WIDTH];

    div_sub_stage #(
        .WIDTH (WIDTH)
    ) u_sub (
        .a     (r_shift),
        .b     ({1'b0, d_reg}),
        .diff  (sub_diff),
        .carry (sub_carry)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        q_iter = q_reg << 1;
        r_iter = r_shift;
        if (sub_carry) begin
            q_iter[0] = 1'b1;
            r_iter    = sub_diff;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the async reset clears every register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
`ifdef DIV_SIGNED_EN
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        r_reg    <= '0;
                        cnt      <= '0;
`ifdef DIV_SIGNED_EN
                        q_reg    <= dvd_mag;
                        d_reg    <= dvs_mag;
                        sign_a   <= dividend[WIDTH-1];
                        sign_b   <= divisor[WIDTH-1];
`else
                        q_reg    <= dividend;
                        d_reg    <= divisor;
`endif
                        if (divisor == '0) begin
                            state       <= DONE;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                        end else begin
                            state       <= RUN;
                            div_by_zero <= 1'b0;
                        end
                    end
                end

                RUN: begin
                    q_reg <= q_iter;
                    r_reg <= r_iter;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
`ifdef DIV_SIGNED_EN
                        state     <= FIXUP;
`else
                        state     <= DONE;
                        quotient  <= q_iter;
                        remainder <= r_iter[WIDTH-1:0];
                        out_valid <= 1'b1;
`endif
                    end
                end

`ifdef DIV_SIGNED_EN
                // Truncating division: quotient sign from the sign mismatch, remainder follows the dividend.
                FIXUP: begin
                    state     <= DONE;
                    quotient  <= (sign_a ^ sign_b) ? -q_reg : q_reg;
                    remainder <= sign_a ? -r_reg[WIDTH-1:0] : r_reg[WIDTH-1:0];
                    out_valid <= 1'b1;
                end
`endif

                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
